sar_search: RTL

SAR_SEARCH -- requirements
Module: sar_search

---
 rtl/sar_search.sv | 128 ++++++++++++
 1 files changed

// File: rtl/sar_search.sv
// Successive-approximation (binary) search controller driving an external comparator.
// Optional query counter output is enabled by defining SAR_SEARCH_STATS_EN.
module sar_search #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic [W-1:0] guess,
  output logic         guess_valid,
  input  logic         cmp_valid,
  input  logic         A_gt_B,
  input  logic         A_lt_B,
  input  logic         A_eq_B,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         found,
  output logic         err,
`ifdef SAR_SEARCH_STATS_EN
  output logic [3:0]   query_count,
`endif
  output logic [1:0]   state_dbg
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] QUERY  = 2'd1;
  localparam logic [1:0] UPDATE = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam logic [W-1:0] ONE_W = W'(1);
  localparam logic [W-1:0] MAX_W = '1;

  logic [1:0]   state;
  logic [W-1:0] lo;
  logic [W-1:0] hi;
  logic [W:0]   sum;
  logic [2:0]   rsp;   // {gt, lt, eq} captured at acceptance
  logic [W-1:0] guess_inc;
  logic [W-1:0] guess_dec;

  // Handshake: guess_valid is high only in QUERY and guess is held there;
  // a response is taken on the cycle where guess_valid and cmp_valid are both 1,
  // and cmp_valid in any other cycle has no effect.
  assign sum         = {1'b0, lo} + {1'b0, hi};
  assign guess       = W'(sum >> 1);
  assign guess_inc   = guess + ONE_W;
  assign guess_dec   = guess - ONE_W;
  assign guess_valid = (state == QUERY);
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);
  assign state_dbg   = state;

`ifdef SAR_SEARCH_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      query_count <= 4'd0;
    end else if (state == IDLE && start) begin
      query_count <= 4'd0;
    end else if (state == QUERY && cmp_valid) begin
      query_count <= query_count + 4'd1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      lo     <= '0;
      hi     <= '0;
      rsp    <= 3'b000;
      result <= '0;
      found  <= 1'b0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            lo     <= '0;
            hi     <= MAX_W;
            result <= '0;
            found  <= 1'b0;
            err    <= 1'b0;
            state  <= QUERY;
          end
        end
        QUERY: begin
          if (cmp_valid) begin
            rsp   <= {A_gt_B, A_lt_B, A_eq_B};
            state <= UPDATE;
          end
        end
        UPDATE: begin
          if (!$onehot(rsp)) begin
            err   <= 1'b1;
            found <= 1'b0;
            state <= DONE;
          end else if (rsp[0]) begin
            result <= guess;
            found  <= 1'b1;
            state  <= DONE;
          end else if (rsp[2]) begin
            // Target above guess: the range cannot grow past the top value.
            if (guess == MAX_W) begin
              found <= 1'b0;
              state <= DONE;
            end else begin
              lo    <= guess_inc;
              state <= (guess_inc > hi) ? DONE : QUERY;
            end
          end else begin
            if (guess == '0) begin
              found <= 1'b0;
              state <= DONE;
            end else begin
              hi    <= guess_dec;
              state <= (guess_dec < lo) ? DONE : QUERY;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
